// File: rtl/mem_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_pkg
// Shared types and constants for the memory stage.
//   access_size_t : width of a load/store access (WORD or BYTE)
//   mem_state_t   : memory-stage FSM states (IDLE, REQ, WAIT)
//   BYTE_LANES    : byte lanes of the default 32-bit datapath
//   byte_lanes()  : byte lanes for an arbitrary datapath width
// -----------------------------------------------------------------------------
package mem_stage_pkg;

  typedef enum logic [0:0] {
    WORD = 1'b0,
    BYTE = 1'b1
  } access_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } mem_state_t;

  function automatic int byte_lanes(input int data_width);
    return data_width / 8;
  endfunction

  localparam int BYTE_LANES = byte_lanes(32);

endpackage

// File: rtl/mem_stage_align.sv
// -----------------------------------------------------------------------------
// mem_align
// Combinational byte-lane helper for the memory stage.
// Store side: builds byte enables and replicates the store byte into every
// lane for BYTE accesses; WORD accesses pass the data through untouched.
// Load side: selects the addressed byte of the read data and sign-extends it
// for BYTE loads; WORD loads pass through.
// Ports:
//   store_size/store_offset/store_data -> store_be, store_wdata
//   load_size/load_offset/load_rdata   -> load_data
// -----------------------------------------------------------------------------
module mem_align
  import mem_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  localparam int LANES     = byte_lanes(DATA_WIDTH),
  localparam int LANE_BITS = $clog2(LANES)
) (
  input  access_size_t          store_size,
  input  logic [LANE_BITS-1:0]  store_offset,
  input  logic [DATA_WIDTH-1:0] store_data,
  output logic [LANES-1:0]      store_be,
  output logic [DATA_WIDTH-1:0] store_wdata,
  input  access_size_t          load_size,
  input  logic [LANE_BITS-1:0]  load_offset,
  input  logic [DATA_WIDTH-1:0] load_rdata,
  output logic [DATA_WIDTH-1:0] load_data
);

  logic [7:0] lane_bytes [LANES];
  logic [7:0] load_byte;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign store_be[gi]           = (store_size == WORD) || (store_offset == LANE_BITS'(gi));
    // Byte stores put the low byte on every lane; the byte enable picks one.
    assign store_wdata[8*gi +: 8] = (store_size == WORD) ? store_data[8*gi +: 8]
                                                         : store_data[7:0];
    assign lane_bytes[gi]         = load_rdata[8*gi +: 8];
  end

  assign load_byte = lane_bytes[load_offset];
  assign load_data = (load_size == WORD) ? load_rdata
                                         : {{(DATA_WIDTH-8){load_byte[7]}}, load_byte};

endmodule

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// Memory stage of the multi-cycle pipeline, fed by the registered ALU-stage
// outputs. Non-memory instructions pass to writeback in one cycle. Loads and
// stores register a request, present it with valid/ready, wait for a
// valid-only response, then retire to writeback. mem_stall_o freezes the
// upstream stages while an access is in flight.
//
// Ports:
//   clk_i, rst_i (async, active low)
//   valid_i, reg_wr_en_i, is_load_i, is_store_i, alu_result_i,
//   store_data_i, wr_reg_i, access_size_i      : instruction from ALU stage
//   mem_stall_o                                : freeze upstream
//   dmem_req_valid_o/ready_i, dmem_addr_o, dmem_wr_en_o, dmem_be_o,
//   dmem_wdata_o                               : memory request channel
//   dmem_rsp_valid_i, dmem_rdata_i             : memory response channel
//   wb_valid_o, wb_reg_wr_en_o, wb_wr_reg_o, wb_data_o : toward writeback
//
// Build option MEM_STAGE_MISALIGN_CHECK_EN: adds misalign_o/misalign_addr_o.
// A WORD access with nonzero low address bits then retires at once without a
// memory request and reports the address. Without it the low address bits
// are silently cleared.
// -----------------------------------------------------------------------------
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int REGISTER_WIDTH = 5
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      valid_i,
  input  logic                      reg_wr_en_i,
  input  logic                      is_load_i,
  input  logic                      is_store_i,
  input  logic [DATA_WIDTH-1:0]     alu_result_i,
  input  logic [DATA_WIDTH-1:0]     store_data_i,
  input  logic [REGISTER_WIDTH-1:0] wr_reg_i,
  input  access_size_t              access_size_i,
  output logic                      mem_stall_o,
  output logic                      dmem_req_valid_o,
  input  logic                      dmem_req_ready_i,
  output logic [ADDR_WIDTH-1:0]     dmem_addr_o,
  output logic                      dmem_wr_en_o,
  output logic [DATA_WIDTH/8-1:0]   dmem_be_o,
  output logic [DATA_WIDTH-1:0]     dmem_wdata_o,
  input  logic                      dmem_rsp_valid_i,
  input  logic [DATA_WIDTH-1:0]     dmem_rdata_i,
  output logic                      wb_valid_o,
  output logic                      wb_reg_wr_en_o,
  output logic [REGISTER_WIDTH-1:0] wb_wr_reg_o,
  output logic [DATA_WIDTH-1:0]     wb_data_o
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
  ,
  output logic                      misalign_o,
  output logic [ADDR_WIDTH-1:0]     misalign_addr_o
`endif
);

  localparam int LANES     = byte_lanes(DATA_WIDTH);
  localparam int LANE_BITS = $clog2(LANES);

  mem_state_t state_reg, state_next;

  logic                 mem_op;
  logic                 misaligned;
  logic                 start_access;
  logic                 rsp_done;
  logic [LANE_BITS-1:0] req_offset;

  // Attributes of the in-flight access, captured when it is issued so that
  // retirement does not depend on upstream keeping its inputs stable.
  logic                      load_reg;
  logic                      reg_wr_en_reg;
  logic [REGISTER_WIDTH-1:0] wr_reg_reg;
  access_size_t              size_reg;
  logic [LANE_BITS-1:0]      offset_reg;

  logic [LANES-1:0]      be_calc;
  logic [DATA_WIDTH-1:0] wdata_calc;
  logic [DATA_WIDTH-1:0] load_data;

  assign mem_op     = valid_i & (is_load_i | is_store_i);
  assign req_offset = alu_result_i[LANE_BITS-1:0];

`ifdef MEM_STAGE_MISALIGN_CHECK_EN
  assign misaligned = mem_op & (access_size_i == WORD) & (req_offset != '0);
`else
  assign misaligned = 1'b0;
`endif

  assign start_access = mem_op & ~misaligned;
  assign rsp_done     = (state_reg == WAIT) & dmem_rsp_valid_i;

  // Stall drops in the response cycle so the next instruction can enter on
  // the same edge that retires this one.
  assign mem_stall_o = ((state_reg == IDLE) & start_access)
                     | (state_reg == REQ)
                     | ((state_reg == WAIT) & ~dmem_rsp_valid_i);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_access)     state_next = REQ;
      REQ:     if (dmem_req_ready_i) state_next = WAIT;
      WAIT:    if (dmem_rsp_valid_i) state_next = IDLE;
      default:                       state_next = IDLE;
    endcase
  end

  mem_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_align (
    .store_size   (access_size_i),
    .store_offset (req_offset),
    .store_data   (store_data_i),
    .store_be     (be_calc),
    .store_wdata  (wdata_calc),
    .load_size    (size_reg),
    .load_offset  (offset_reg),
    .load_rdata   (dmem_rdata_i),
    .load_data    (load_data)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg        <= IDLE;
      dmem_req_valid_o <= 1'b0;
      dmem_addr_o      <= '0;
      dmem_wr_en_o     <= 1'b0;
      dmem_be_o        <= '0;
      dmem_wdata_o     <= '0;
      wb_valid_o       <= 1'b0;
      wb_reg_wr_en_o   <= 1'b0;
      wb_wr_reg_o      <= '0;
      wb_data_o        <= '0;
      load_reg         <= 1'b0;
      reg_wr_en_reg    <= 1'b0;
      wr_reg_reg       <= '0;
      size_reg         <= WORD;
      offset_reg       <= '0;
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
      misalign_o       <= 1'b0;
      misalign_addr_o  <= '0;
`endif
    end else begin
      state_reg  <= state_next;
      // Writeback valid and misalign flag are single-cycle pulses.
      wb_valid_o <= 1'b0;
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
      misalign_o <= 1'b0;
`endif
      case (state_reg)
        IDLE: begin
          if (start_access) begin
            dmem_req_valid_o <= 1'b1;
            dmem_addr_o      <= {alu_result_i[ADDR_WIDTH-1:LANE_BITS], {LANE_BITS{1'b0}}};
            dmem_wr_en_o     <= is_store_i;
            dmem_be_o        <= be_calc;
            dmem_wdata_o     <= wdata_calc;
            load_reg         <= is_load_i;
            reg_wr_en_reg    <= reg_wr_en_i;
            wr_reg_reg       <= wr_reg_i;
            size_reg         <= access_size_i;
            offset_reg       <= req_offset;
            wb_reg_wr_en_o   <= 1'b0;
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
          end else if (misaligned) begin
            wb_valid_o      <= 1'b1;
            wb_reg_wr_en_o  <= 1'b0;
            wb_wr_reg_o     <= wr_reg_i;
            wb_data_o       <= alu_result_i;
            misalign_o      <= 1'b1;
            misalign_addr_o <= alu_result_i[ADDR_WIDTH-1:0];
`endif
          end else begin
            wb_valid_o     <= valid_i;
            wb_reg_wr_en_o <= valid_i & reg_wr_en_i;
            // Data/register fields hold while no instruction is retiring.
            if (valid_i) begin
              wb_data_o   <= alu_result_i;
              wb_wr_reg_o <= wr_reg_i;
            end
          end
        end
        REQ: begin
          if (dmem_req_ready_i) dmem_req_valid_o <= 1'b0;
        end
        WAIT: begin
          if (rsp_done) begin
            wb_valid_o     <= 1'b1;
            wb_reg_wr_en_o <= load_reg & reg_wr_en_reg;
            wb_wr_reg_o    <= wr_reg_reg;
            wb_data_o      <= load_reg ? load_data : '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
// Self-checking bench for mem_stage. Directed cases plus randomized traffic,
// with expectations computed from arithmetic models of the access rules.
// Optional misalign ports are connected when MEM_STAGE_MISALIGN_CHECK_EN is set.
// -----------------------------------------------------------------------------
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid = 1'b0, reg_wr_en = 1'b0, is_load = 1'b0, is_store = 1'b0;
  logic [31:0] alu_result = '0, store_data = '0, rdata = '0;
  logic [4:0]  wr_reg = '0;
  access_size_t size = WORD;
  logic        stall, req_valid, ready = 1'b0, wr_en, rsp = 1'b0;
  logic [31:0] addr, wdata, wb_data;
  logic [3:0]  be;
  logic        wb_valid, wb_reg_wr_en;
  logic [4:0]  wb_wr_reg;
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
  logic        misalign;
  logic [31:0] misalign_addr;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_stage #(
    .DATA_WIDTH     (32),
    .ADDR_WIDTH     (32),
    .REGISTER_WIDTH (5)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .valid_i          (valid),
    .reg_wr_en_i      (reg_wr_en),
    .is_load_i        (is_load),
    .is_store_i       (is_store),
    .alu_result_i     (alu_result),
    .store_data_i     (store_data),
    .wr_reg_i         (wr_reg),
    .access_size_i    (size),
    .mem_stall_o      (stall),
    .dmem_req_valid_o (req_valid),
    .dmem_req_ready_i (ready),
    .dmem_addr_o      (addr),
    .dmem_wr_en_o     (wr_en),
    .dmem_be_o        (be),
    .dmem_wdata_o     (wdata),
    .dmem_rsp_valid_i (rsp),
    .dmem_rdata_i     (rdata),
    .wb_valid_o       (wb_valid),
    .wb_reg_wr_en_o   (wb_reg_wr_en),
    .wb_wr_reg_o      (wb_wr_reg),
    .wb_data_o        (wb_data)
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
    ,
    .misalign_o       (misalign),
    .misalign_addr_o  (misalign_addr)
`endif
  );

  // ---------------- reference model ----------------
  function automatic logic [3:0] model_be(input bit word, input logic [31:0] a);
    if (word) return 4'hF;
    return 4'(1 << (a % 4));
  endfunction

  function automatic logic [31:0] model_wdata(input bit word, input logic [31:0] d);
    if (word) return d;
    return (d % 256) * 32'h0101_0101;
  endfunction

  function automatic logic [31:0] model_wb(input bit ld, input bit word,
                                           input logic [31:0] a, input logic [31:0] r);
    int b;
    if (!ld) return 32'h0;
    if (word) return r;
    b = int'((r >> (8 * (a % 4))) % 256);
    if (b >= 128) b = b - 256;
    return 32'(b);
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({stall, req_valid, wr_en, wb_valid, wb_reg_wr_en} !== 5'b0 ||
        addr !== 32'h0 || be !== 4'h0 || wdata !== 32'h0 || wb_data !== 32'h0 || wb_wr_reg !== 5'h0) begin
      bad++;
      $display("FAIL reset_state: got stall=%b req=%b wr=%b wbv=%b wbw=%b addr=%h be=%h wdata=%h wbd=%h reg=%0d want all zero",
               stall, req_valid, wr_en, wb_valid, wb_reg_wr_en, addr, be, wdata, wb_data, wb_wr_reg);
    end
    @(negedge clk);
    rst = 1'b1;
    $display("reset: released");
  endtask

  task automatic do_alu(input logic [31:0] d, input logic [4:0] rd, input bit wen);
    @(posedge clk); #1;
    valid = 1'b1; is_load = 1'b0; is_store = 1'b0; alu_result = d; wr_reg = rd; reg_wr_en = wen;
    store_data = $urandom;
    @(negedge clk);
    total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL alu_stall: got %b want 0", stall); end
    @(posedge clk); #1;
    valid = 1'b0;
    total++;
    if (wb_valid !== 1'b1 || wb_data !== d || wb_wr_reg !== rd || wb_reg_wr_en !== wen) begin
      bad++;
      $display("FAIL alu_wb: got v=%b d=%h r=%0d we=%b want v=1 d=%h r=%0d we=%b",
               wb_valid, wb_data, wb_wr_reg, wb_reg_wr_en, d, rd, wen);
    end
    $display("alu: data=%h reg=%0d we=%b", d, rd, wen);
  endtask

  task automatic do_mem(input bit ld, input bit word, input logic [31:0] a, input logic [31:0] sd,
                        input logic [31:0] rv, input int rdy_dly, input int rsp_dly,
                        input logic [4:0] rd, input bit wen, input bit spur);
    logic [31:0] e_addr, e_wdata, e_wb;
    logic [3:0]  e_be;
    logic        e_wr, e_we;
    int          stalls;
    e_addr  = a - (a % 4);
    e_be    = model_be(word, a);
    e_wdata = model_wdata(word, sd);
    e_wb    = model_wb(ld, word, a, rv);
    e_wr    = ~ld;
    e_we    = ld & wen;
    stalls  = 0;
    @(posedge clk); #1;
    valid = 1'b1; is_load = ld; is_store = ~ld; size = word ? WORD : BYTE;
    alu_result = a; store_data = sd; wr_reg = rd; reg_wr_en = wen; ready = 1'b0; rsp = 1'b0;
    @(negedge clk);
    if (stall === 1'b1) stalls++;
    total++;
    if (req_valid !== 1'b0) begin bad++; $display("FAIL entry_req_valid: got %b want 0", req_valid); end
    for (int k = 0; k <= rdy_dly; k++) begin
      @(posedge clk); #1;
      ready = (k == rdy_dly); rsp = spur; rdata = $urandom;
      @(negedge clk);
      if (stall === 1'b1) stalls++;
      total++;
      if (req_valid !== 1'b1 || addr !== e_addr || be !== e_be || wdata !== e_wdata ||
          wr_en !== e_wr || wb_valid !== 1'b0) begin
        bad++;
        $display("FAIL req_fields: got v=%b a=%h be=%b wd=%h wr=%b wbv=%b want v=1 a=%h be=%b wd=%h wr=%b wbv=0",
                 req_valid, addr, be, wdata, wr_en, wb_valid, e_addr, e_be, e_wdata, e_wr);
      end
    end
    for (int k = 0; k < rsp_dly; k++) begin
      @(posedge clk); #1;
      ready = 1'b0; rsp = 1'b0; rdata = $urandom;
      @(negedge clk);
      if (stall === 1'b1) stalls++;
      total++;
      if (req_valid !== 1'b0 || wb_valid !== 1'b0) begin
        bad++;
        $display("FAIL wait_phase: got req=%b wbv=%b want 0 0", req_valid, wb_valid);
      end
    end
    @(posedge clk); #1;
    ready = 1'b0; rsp = 1'b1; rdata = rv;
    @(negedge clk);
    if (stall === 1'b1) stalls++;
    @(posedge clk); #1;
    rsp = 1'b0; valid = 1'b0; rdata = $urandom;
    total++;
    if (stalls != 2 + rdy_dly + rsp_dly) begin
      bad++;
      $display("FAIL stall_cycles: got %0d want %0d", stalls, 2 + rdy_dly + rsp_dly);
    end
    total++;
    if (wb_valid !== 1'b1 || wb_data !== e_wb || wb_reg_wr_en !== e_we || wb_wr_reg !== rd) begin
      bad++;
      $display("FAIL mem_wb: got v=%b d=%h we=%b r=%0d want v=1 d=%h we=%b r=%0d",
               wb_valid, wb_data, wb_reg_wr_en, wb_wr_reg, e_wb, e_we, rd);
    end
    @(posedge clk); #1;
    total++;
    if (wb_valid !== 1'b0) begin bad++; $display("FAIL wb_pulse: got %b want 0", wb_valid); end
    $display("mem: %s%s addr=%h sd=%h rd=%h rdy=%0d rsp=%0d -> wb=%h",
             ld ? "L" : "S", word ? "W" : "B", a, sd, rv, rdy_dly, rsp_dly, e_wb);
  endtask

`ifdef MEM_STAGE_MISALIGN_CHECK_EN
  task automatic do_misalign(input logic [31:0] a, input logic [4:0] rd, input bit ld);
    @(posedge clk); #1;
    valid = 1'b1; is_load = ld; is_store = ~ld; size = WORD; alu_result = a;
    wr_reg = rd; reg_wr_en = 1'b1; ready = 1'b1;
    @(negedge clk);
    total++;
    if (stall !== 1'b0 || req_valid !== 1'b0) begin
      bad++; $display("FAIL misalign_entry: got stall=%b req=%b want 0 0", stall, req_valid);
    end
    @(posedge clk); #1;
    valid = 1'b0; ready = 1'b0;
    total++;
    if (wb_valid !== 1'b1 || wb_reg_wr_en !== 1'b0 || misalign !== 1'b1 ||
        misalign_addr !== a || req_valid !== 1'b0) begin
      bad++;
      $display("FAIL misalign_wb: got v=%b we=%b m=%b ma=%h req=%b want 1 0 1 %h 0",
               wb_valid, wb_reg_wr_en, misalign, misalign_addr, req_valid, a);
    end
    @(posedge clk); #1;
    total++;
    if (misalign !== 1'b0 || wb_valid !== 1'b0) begin
      bad++; $display("FAIL misalign_pulse: got m=%b v=%b want 0 0", misalign, wb_valid);
    end
    $display("misalign: addr=%h", a);
  endtask
`endif

  task automatic test_alu();
    do_alu(32'h0000_1234, 5'd3, 1'b1);
    do_alu(32'hCAFE_0001, 5'd9, 1'b0);
  endtask

  task automatic test_mem_directed();
    do_mem(1'b1, 1'b1, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 0, 5'd4, 1'b1, 1'b0);
    do_mem(1'b1, 1'b0, 32'h103, 32'h0, 32'h80FF_FF7F, 0, 0, 5'd5, 1'b1, 1'b0);
    do_mem(1'b0, 1'b0, 32'h42, 32'h0000_00A5, 32'h1234_5678, 3, 0, 5'd6, 1'b1, 1'b1);
    do_mem(1'b0, 1'b1, 32'h200, 32'h1122_3344, 32'h0, 1, 2, 5'd7, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] d [4];
    logic [4:0]  r [4];
    for (int i = 0; i < 4; i++) begin
      d[i] = $urandom; r[i] = 5'($urandom_range(1, 31));
    end
    for (int i = 0; i <= 4; i++) begin
      @(posedge clk); #1;
      if (i > 0) begin
        total++;
        if (wb_valid !== 1'b1 || wb_data !== d[i-1] || wb_wr_reg !== r[i-1]) begin
          bad++;
          $display("FAIL b2b_wb[%0d]: got v=%b d=%h r=%0d want 1 %h %0d",
                   i - 1, wb_valid, wb_data, wb_wr_reg, d[i-1], r[i-1]);
        end
      end
      if (i < 4) begin
        valid = 1'b1; is_load = 1'b0; is_store = 1'b0; alu_result = d[i]; wr_reg = r[i]; reg_wr_en = 1'b1;
      end else begin
        valid = 1'b0;
      end
    end
    $display("b2b: 4 alu ops");
  endtask

  task automatic test_ignored_inputs();
    // Memory flags without valid, plus a stray response in IDLE.
    @(posedge clk); #1;
    valid = 1'b0; is_load = 1'b1; is_store = 1'b1; rsp = 1'b1; rdata = $urandom;
    @(negedge clk);
    total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL invalid_stall: got %b want 0", stall); end
    @(posedge clk); #1;
    rsp = 1'b0; is_load = 1'b0; is_store = 1'b0;
    total++;
    if (wb_valid !== 1'b0 || req_valid !== 1'b0) begin
      bad++; $display("FAIL invalid_ignored: got wbv=%b req=%b want 0 0", wb_valid, req_valid);
    end
    $display("ignored: flags without valid, idle response");
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    valid = 1'b1; is_load = 1'b1; is_store = 1'b0; size = WORD; alu_result = 32'h100;
    wr_reg = 5'd12; reg_wr_en = 1'b1;
    @(posedge clk); #1;
    ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
    @(negedge clk);
    total++;
    if (stall !== 1'b1 || req_valid !== 1'b0) begin
      bad++; $display("FAIL mid_wait: got stall=%b req=%b want 1 0", stall, req_valid);
    end
    #2;
    rst = 1'b0; valid = 1'b0; is_load = 1'b0;
    #1;
    total++;
    if ({stall, req_valid, wr_en, wb_valid, wb_reg_wr_en} !== 5'b0 ||
        addr !== 32'h0 || be !== 4'h0 || wdata !== 32'h0 || wb_data !== 32'h0 || wb_wr_reg !== 5'h0) begin
      bad++;
      $display("FAIL mid_reset: got stall=%b req=%b addr=%h be=%h wbv=%b wbd=%h reg=%0d want all zero",
               stall, req_valid, addr, be, wb_valid, wb_data, wb_wr_reg);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rsp = 1'b1; rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    rsp = 1'b0;
    total++;
    if (wb_valid !== 1'b0 || wb_data !== 32'h0) begin
      bad++; $display("FAIL late_rsp: got wbv=%b wbd=%h want 0 0", wb_valid, wb_data);
    end
    @(posedge clk); #1;
    total++;
    if (wb_valid !== 1'b0 || stall !== 1'b0) begin
      bad++; $display("FAIL late_rsp_after: got wbv=%b stall=%b want 0 0", wb_valid, stall);
    end
    $display("reset_mid: access aborted");
  endtask

  task automatic test_misaligned();
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
    do_misalign(32'h102, 5'd8, 1'b1);
    do_misalign(32'h301, 5'd2, 1'b0);
`else
    do_mem(1'b1, 1'b1, 32'h102, 32'h0, 32'h0BAD_F00D, 0, 1, 5'd8, 1'b1, 1'b0);
`endif
  endtask

  task automatic test_random();
    int kind;
    logic [31:0] a;
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 4);
      a = 32'h1000 + 32'($urandom_range(0, 255));
      if (kind == 0) begin
        do_alu($urandom, 5'($urandom), 1'($urandom));
      end else begin
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
        if (kind <= 2 && (a % 4) != 0) begin
          do_misalign(a, 5'($urandom), kind == 1);
          continue;
        end
`endif
        do_mem(kind == 1 || kind == 3, kind <= 2, a, $urandom, $urandom,
               $urandom_range(0, 3), $urandom_range(0, 3), 5'($urandom), 1'($urandom),
               1'($urandom));
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_alu();
    test_mem_directed();
    test_back_to_back();
    test_ignored_inputs();
    test_misaligned();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
